// File: rtl/smf_frame_sequencer.sv
// Frame sequencer for the switching median filter: paces the raster stream, flags full
// 3x3 windows with border masks, and tags results through the stage pipeline.
module smf_frame_sequencer #(
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int PIPE_LAT = 3,
    parameter int CW       = 9
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Start,
    input  logic          In_Valid,
    output logic          In_Ready,
    input  logic          Out_Ready,
    output logic          Line_Shift,
    output logic          Stage_En,
    output logic          Win_Valid,
    output logic [8:0]    Border_Mask,
    output logic          Out_Valid,
    output logic [CW-1:0] Out_Row,
    output logic [CW-1:0] Out_Col,
    output logic          Busy,
    output logic          Frame_Done
);

    // state | meaning
    // IDLE  | waiting for Start
    // PRIME | filling line buffers, no complete window yet
    // RUN   | accepting pixels, windows valid
    // FLUSH | IMG_W+1 data-less shifts to push out the last row's windows
    // DRAIN | stages run until the tag pipe is empty
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] PRIME = 3'd1;
    localparam logic [2:0] RUN   = 3'd2;
    localparam logic [2:0] FLUSH = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;

    localparam int NPIX = IMG_W * IMG_H;
    localparam int SW   = $clog2(NPIX + IMG_W + 1);

    localparam logic [SW-1:0] S_PRIME_END = SW'(IMG_W);
    localparam logic [SW-1:0] S_WIN_FIRST = SW'(IMG_W + 1);
    localparam logic [SW-1:0] S_LAST_PIX  = SW'(NPIX - 1);
    localparam logic [SW-1:0] S_LAST      = SW'(NPIX + IMG_W);
    localparam logic [CW-1:0] ROW_LAST    = CW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_LAST    = CW'(IMG_W - 1);

    logic [2:0]          state_q, state_d;
    logic [SW-1:0]       s_q, s_d;
    logic [CW-1:0]       row_q, row_d;
    logic [CW-1:0]       col_q, col_d;
    logic [PIPE_LAT-1:0] pv_q, pv_d;
    logic [CW-1:0]       pr_q [PIPE_LAT];
    logic [CW-1:0]       pr_d [PIPE_LAT];
    logic [CW-1:0]       pc_q [PIPE_LAT];
    logic [CW-1:0]       pc_d [PIPE_LAT];
    logic                frame_done_q, frame_done_d;
    logic                active;

    always_comb begin
        active     = (state_q != IDLE);
        Stage_En   = active & Out_Ready;
        In_Ready   = Out_Ready & ((state_q == PRIME) | (state_q == RUN));
        Line_Shift = Stage_En & ((In_Valid & In_Ready) | (state_q == FLUSH));
        Win_Valid  = Line_Shift & (s_q >= S_WIN_FIRST);

        Border_Mask = '0;
        if (Win_Valid) begin
            if (row_q == '0)       Border_Mask = Border_Mask | 9'h007;
            if (row_q == ROW_LAST) Border_Mask = Border_Mask | 9'h1C0;
            if (col_q == '0)       Border_Mask = Border_Mask | 9'h049;
            if (col_q == COL_LAST) Border_Mask = Border_Mask | 9'h124;
        end

        Out_Valid  = pv_q[PIPE_LAT-1];
        Out_Row    = Out_Valid ? pr_q[PIPE_LAT-1] : '0;
        Out_Col    = Out_Valid ? pc_q[PIPE_LAT-1] : '0;
        Busy       = active;
        Frame_Done = frame_done_q;
    end

    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        row_d        = row_q;
        col_d        = col_q;
        pv_d         = pv_q;
        pr_d         = pr_q;
        pc_d         = pc_q;
        frame_done_d = 1'b0;

        if (Line_Shift) s_d = s_q + 1'b1;

        if (Win_Valid) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        // Stage_En cycles without a window push a bubble into the tag pipe
        if (Stage_En) begin
            pv_d[0] = Win_Valid;
            pr_d[0] = row_q;
            pc_d[0] = col_q;
            for (int i = 1; i < PIPE_LAT; i++) begin
                pv_d[i] = pv_q[i-1];
                pr_d[i] = pr_q[i-1];
                pc_d[i] = pc_q[i-1];
            end
        end

        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = PRIME;
                    s_d     = '0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            PRIME: if (Line_Shift && (s_q == S_PRIME_END)) state_d = RUN;
            RUN:   if (Line_Shift && (s_q == S_LAST_PIX))  state_d = FLUSH;
            FLUSH: if (Line_Shift && (s_q == S_LAST))      state_d = DRAIN;
            DRAIN: begin
                // leave as the last result is taken so Frame_Done follows it directly
                if (pv_d == '0) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= IDLE;
            s_q          <= '0;
            row_q        <= '0;
            col_q        <= '0;
            pv_q         <= '0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                pr_q[i] <= '0;
                pc_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            row_q        <= row_d;
            col_q        <= col_d;
            pv_q         <= pv_d;
            frame_done_q <= frame_done_d;
            for (int i = 0; i < PIPE_LAT; i++) begin
                pr_q[i] <= pr_d[i];
                pc_q[i] <= pc_d[i];
            end
        end
    end

endmodule

// File: tb/tb_smf_frame_sequencer.sv
// Bench for smf_frame_sequencer on a 4x3 image: every cycle is compared against a
// frame model built from shift counts, tap geometry and a latency-tagged result queue.
module tb_smf_frame_sequencer;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int PL   = 2;
    localparam int CWT  = 9;
    localparam int NPIX = W * H;

    logic           Clk = 1'b0;
    logic           Rst;
    logic           Start;
    logic           In_Valid;
    logic           In_Ready;
    logic           Out_Ready;
    logic           Line_Shift;
    logic           Stage_En;
    logic           Win_Valid;
    logic [8:0]     Border_Mask;
    logic           Out_Valid;
    logic [CWT-1:0] Out_Row;
    logic [CWT-1:0] Out_Col;
    logic           Busy;
    logic           Frame_Done;

    smf_frame_sequencer #(.IMG_W(W), .IMG_H(H), .PIPE_LAT(PL), .CW(CWT)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Out_Ready(Out_Ready), .Line_Shift(Line_Shift), .Stage_En(Stage_En),
        .Win_Valid(Win_Valid), .Border_Mask(Border_Mask), .Out_Valid(Out_Valid),
        .Out_Row(Out_Row), .Out_Col(Out_Col), .Busy(Busy), .Frame_Done(Frame_Done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int t;
        int r;
        int c;
    } ent_t;

    int checks = 0;
    int errors = 0;

    // reference model
    bit   in_frame;
    int   shifts;
    int   e_ticks;
    bit   done_exp;
    ent_t q[$];

    // observations of the DUT for the current frame
    int cyc = 0;
    int n_ir, n_ls, n_wv, n_fd, n_out;
    int first_wv_shift, first_wv_cyc, first_ov_cyc;
    logic [8:0] first_mask;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] mask_of(input int r, input int c);
        logic [8:0] m;
        int tr, tc;
        m = '0;
        for (int k = 0; k < 9; k++) begin
            tr = r + k / 3 - 1;
            tc = c + k % 3 - 1;
            if (tr < 0 || tr >= H || tc < 0 || tc >= W) m[k] = 1'b1;
        end
        return m;
    endfunction

    task automatic model_reset();
        in_frame = 0;
        shifts   = 0;
        e_ticks  = 0;
        done_exp = 0;
        q.delete();
    endtask

    task automatic clear_obs();
        n_ir = 0; n_ls = 0; n_wv = 0; n_fd = 0; n_out = 0;
        first_wv_shift = 0; first_wv_cyc = -1; first_ov_cyc = -1; first_mask = '0;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_in_ready"},   In_Ready,    0);
        chk({pfx, "_line_shift"}, Line_Shift,  0);
        chk({pfx, "_stage_en"},   Stage_En,    0);
        chk({pfx, "_win_valid"},  Win_Valid,   0);
        chk({pfx, "_mask"},       Border_Mask, 0);
        chk({pfx, "_out_valid"},  Out_Valid,   0);
        chk({pfx, "_out_row"},    Out_Row,     0);
        chk({pfx, "_out_col"},    Out_Col,     0);
        chk({pfx, "_busy"},       Busy,        0);
        chk({pfx, "_frame_done"}, Frame_Done,  0);
    endtask

    // one clock: drive at posedge+1, compare at negedge, advance the model
    task automatic cycle(input logic st, input logic iv, input logic ordy);
        bit acc, fl, se, ir, ls, wv, ov, pop_last, start_ok;
        int k, wr, wc, orow, ocol;
        logic [8:0] m;
        ent_t e;
        Start = st; In_Valid = iv; Out_Ready = ordy;
        @(negedge Clk);
        acc = in_frame && (shifts < NPIX);
        fl  = in_frame && (shifts >= NPIX) && (shifts < NPIX + W + 1);
        se  = in_frame && ordy;
        ir  = acc && ordy;
        ls  = se && ((iv && ir) || fl);
        wv  = ls && (shifts >= W + 1);
        wr = 0; wc = 0; m = '0;
        if (wv) begin
            k  = shifts - (W + 1);
            wr = k / W;
            wc = k % W;
            m  = mask_of(wr, wc);
        end
        ov   = (q.size() > 0) && (q[0].t + PL == e_ticks);
        orow = ov ? q[0].r : 0;
        ocol = ov ? q[0].c : 0;

        chk("in_ready",    In_Ready,    ir);
        chk("stage_en",    Stage_En,    se);
        chk("line_shift",  Line_Shift,  ls);
        chk("win_valid",   Win_Valid,   wv);
        chk("border_mask", Border_Mask, m);
        chk("out_valid",   Out_Valid,   ov);
        chk("out_row",     Out_Row,     orow);
        chk("out_col",     Out_Col,     ocol);
        chk("busy",        Busy,        in_frame);
        chk("frame_done",  Frame_Done,  done_exp);
        if (wv && wr == 1 && wc == 1) chk("mask_centre_1_1", Border_Mask, 9'h000);
        if (wv && wr == 2 && wc == 3) chk("mask_centre_2_3", Border_Mask, 9'h1E4);
        if (wv && wr == 0 && wc == 3) chk("mask_centre_0_3", Border_Mask, 9'h127);

        if (In_Ready === 1'b1) n_ir++;
        if (Line_Shift === 1'b1) n_ls++;
        if (Win_Valid === 1'b1) begin
            n_wv++;
            if (n_wv == 1) begin
                first_wv_shift = n_ls;
                first_wv_cyc   = cyc;
                first_mask     = Border_Mask;
            end
        end
        if (Out_Valid === 1'b1 && first_ov_cyc < 0) first_ov_cyc = cyc;
        if (Frame_Done === 1'b1) n_fd++;
        if (Out_Valid === 1'b1 && ordy) begin
            chk("raster_tag", {Out_Row, Out_Col}, ((n_out / W) << CWT) | (n_out % W));
            n_out++;
        end

        start_ok = st && !in_frame;
        if (ls) shifts++;
        if (wv) begin
            e.t = e_ticks; e.r = wr; e.c = wc;
            q.push_back(e);
        end
        if (se) e_ticks++;
        pop_last = 0;
        if (ov && ordy) begin
            pop_last = (q[0].r == H - 1) && (q[0].c == W - 1);
            void'(q.pop_front());
        end
        done_exp = pop_last;
        if (pop_last) in_frame = 0;
        if (start_ok) begin
            in_frame = 1;
            shifts   = 0;
        end
        cyc++;
        @(posedge Clk);
        #1;
    endtask

    // mode 0: steady; 1: 5-cycle Out_Ready stall mid-RUN; 2: random In_Valid and Start;
    // 3: random In_Valid, Out_Ready and Start. chain issues Start in the Frame_Done cycle.
    task automatic run_frame(input int mode, input bit started, input bit chain);
        int n;
        bit stalled;
        logic st, iv, ordy;
        clear_obs();
        stalled = 0;
        if (!started) cycle(1'b1, 1'b1, 1'b1);
        n = 0;
        while (!done_exp && n < 600) begin
            st = 1'b0; iv = 1'b1; ordy = 1'b1;
            case (mode)
                1: begin
                    if (!stalled && shifts == 8) begin
                        repeat (5) cycle(1'b0, 1'b1, 1'b0);
                        stalled = 1;
                    end
                end
                2: begin
                    iv = 1'($urandom_range(0, 1));
                    st = 1'($urandom_range(0, 7) == 0);
                end
                3: begin
                    iv   = 1'($urandom_range(0, 1));
                    ordy = 1'($urandom_range(0, 3) != 0);
                    st   = 1'($urandom_range(0, 7) == 0);
                end
                default: ;
            endcase
            cycle(st, iv, ordy);
            n++;
        end
        chk("frame_budget", (n < 600), 1);
        cycle(chain, 1'b1, 1'b1);
        chk("frame_done_count", n_fd, 1);
        chk("result_count", n_out, NPIX);
        chk("win_count", n_wv, NPIX);
        chk("shift_count", n_ls, NPIX + W + 1);
    endtask

    initial begin
        int n;
        Rst = 1'b1; Start = 1'b0; In_Valid = 1'b1; Out_Ready = 1'b1;
        model_reset();
        clear_obs();
        #12;
        chk_all_zero("reset");
        @(negedge Clk);
        Rst = 1'b0;
        @(posedge Clk);
        #1;
        cycle(1'b0, 1'b1, 1'b1);

        // steady frame, then a Start in its Frame_Done cycle begins the stall frame
        run_frame(0, 1'b0, 1'b1);
        chk("t1_in_ready_cycles", n_ir, NPIX);
        chk("t1_first_win_shift", first_wv_shift, W + 2);
        chk("t1_first_mask", first_mask, 9'h04F);
        chk("t3_latency", first_ov_cyc - first_wv_cyc, PL);

        run_frame(1, 1'b1, 1'b0);
        run_frame(2, 1'b0, 1'b0);
        repeat (3) run_frame(3, 1'b0, 1'b0);

        // abort in FLUSH
        clear_obs();
        cycle(1'b1, 1'b1, 1'b1);
        n = 0;
        while (shifts < NPIX + 2 && n < 100) begin
            cycle(1'b0, 1'b1, 1'b1);
            n++;
        end
        chk("abort_reached_flush", (shifts >= NPIX + 2), 1);
        Rst = 1'b1;
        #1;
        chk_all_zero("abort");
        model_reset();
        @(negedge Clk);
        Rst = 1'b0;
        @(posedge Clk);
        #1;
        repeat (4) cycle(1'b0, 1'b1, 1'b1);
        chk("abort_no_frame_done", n_fd, 0);
        run_frame(0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/smf_frame_sequencer.md
Name:
smf_frame_sequencer

Overview:
Frame-level controller for the switching median filter. It accepts a raster pixel stream, issues line-buffer shift strobes, and marks when a complete 3x3 window is presented to the detection and noise-removal stages. It also supplies per-tap border masks so that out-of-image taps are forced non-noisy (F=0), and tracks windows through the stage pipeline. Results leave with row/column tags and an end-of-frame pulse.

Parameters:
IMG_W, 256, image width in pixels (>=3)
IMG_H, 256, image height in pixels (>=3)
PIPE_LAT, 3, Stage_En cycles from Win_Valid to filtered pixel at stage output (>=1)
CW, 9, row/column counter width (2^CW > max(IMG_W,IMG_H))

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  asynchronous active-high reset
Start  in  1  begin a frame; sampled only in IDLE
In_Valid  in  1  upstream pixel available
In_Ready  out  1  sequencer accepts pixel this cycle
Out_Ready  in  1  downstream can take a result; low stalls the whole pipeline
Line_Shift  out  1  shift line buffers/window registers this cycle
Stage_En  out  1  clock enable to detection and removal stages
Win_Valid  out  1  window currently in the window registers is a real centre pixel
Border_Mask  out  9  bit k=1: tap Xk lies outside the image
Out_Valid  out  1  filtered pixel valid at stage output
Out_Row  out  CW  row of the Out_Valid pixel
Out_Col  out  CW  column of the Out_Valid pixel
Busy  out  1  high in any state other than IDLE
Frame_Done  out  1  one-cycle pulse after the last pixel leaves

Behaviour:
- Reset (async, Rst=1): state IDLE. All counters, the valid pipe and the tag pipe are cleared. All outputs are 0.
- Taps are row-major with X4 as the centre. X0..X2 are row r-1, X3/X5 are row r, X6..X8 are row r+1, with columns c-1, c, c+1.
- Border_Mask is combinational from the centre (r,c):
  - r=0 sets bits 0,1,2; r=IMG_H-1 sets bits 6,7,8.
  - c=0 sets bits 0,3,6; c=IMG_W-1 sets bits 2,5,8.
  - Bits are OR-combined. The mask is 0 when Win_Valid=0.
- Stage_En = Out_Ready in every state except IDLE.
- In_Ready = Out_Ready in PRIME and RUN, else 0.
- Line_Shift = Stage_En & ((In_Valid & In_Ready) | state==FLUSH).
- A shift index counter S (0-based) counts Line_Shift events.
- Win_Valid = Line_Shift & (S >= IMG_W+1).
- Centre counters (r,c) advance raster-order on each Win_Valid. c wraps IMG_W-1 to 0 and increments r.
- States:
  - IDLE: Start=1 goes to PRIME and clears S, r, c. Start in any other state is ignored.
  - PRIME: accepting pixels. Go to RUN on the shift with S=IMG_W.
  - RUN: accepting pixels. Go to FLUSH on the shift that accepts the last input pixel (S=IMG_W*IMG_H-1).
  - FLUSH: no input taken. IMG_W+1 shifts are generated without data; the line-buffer contents are don't-care and are masked by Border_Mask. Go to DRAIN on the final shift (S=IMG_W*IMG_H+IMG_W).
  - DRAIN: Stage_En continues until the valid pipe is empty. Then pulse Frame_Done and return to IDLE.
- Counts per frame: total shifts = IMG_W*IMG_H+IMG_W+1; Win_Valid pulses = IMG_W*IMG_H exactly.
- Valid/tag pipe:
  - PIPE_LAT-deep shift register of {Win_Valid, r, c}, advanced only when Stage_En=1.
  - Its head drives Out_Valid/Out_Row/Out_Col.
  - A Stage_En cycle without Line_Shift inserts a bubble (valid=0).
- Stall: with Out_Ready=0, nothing advances. S, r, c, the pipe contents and the outputs all hold, and Out_Valid stays asserted if it was asserted.
- In_Valid=0 in PRIME/RUN with Out_Ready=1: the pipe advances with a bubble; S is unchanged.
- Frame_Done asserts the cycle after the last Out_Valid has been consumed (Out_Valid & Out_Ready).
- Busy=0 from the Frame_Done cycle onward. A Start in the Frame_Done cycle is accepted.
- Mid-frame Rst: immediate abort to IDLE. No Frame_Done is produced.

Test Plan:
1. IMG_W=4, IMG_H=3, PIPE_LAT=2, Out_Ready=1, In_Valid=1 throughout. Pulse Start -> In_Ready high for 12 cycles; 17 Line_Shift pulses; Win_Valid first on the 6th shift with Border_Mask=0x04F; 12 Win_Valid total; Frame_Done exactly once.
2. Same config, centre (1,1) -> Border_Mask=0x000. Centre (2,3) -> Border_Mask=0x1E4. Centre (0,3) -> Border_Mask=0x127.
3. Latency: Win_Valid for centre (0,0) at cycle t with continuous Stage_En -> Out_Valid=1, Out_Row=0, Out_Col=0 at t+2.
4. Deassert Out_Ready for 5 cycles mid-RUN -> In_Ready=0, no Line_Shift, and Out_Valid/Out_Row/Out_Col frozen. Resume -> output sequence is unchanged and no pixel is lost or duplicated (12 results in raster order).
5. Toggle In_Valid randomly (50%) -> still exactly 12 Out_Valid with tags (0,0)..(2,3) in order. Start pulses while Busy are ignored.
6. Assert Rst during FLUSH -> all outputs 0 immediately, state IDLE, no Frame_Done. A following Start runs a full clean frame.
